// File: rtl/alarm_siren_controller_if.sv
// Alarm siren controller board-side signal bundle.
// Inputs from detection/user, outputs to siren, beeper and LEDs.
interface alarm_siren_controller_if;
  logic       trig;
  logic       m;
  logic       ack;
  logic       siren;
  logic       beep;
  logic       mem_led;
  logic [2:0] state;
  logic [7:0] remaining;

  modport master (
    output trig, m, ack,
    input  siren, beep, mem_led, state, remaining
  );

  modport slave (
    input  trig, m, ack,
    output siren, beep, mem_led, state, remaining
  );
endinterface

// File: rtl/alarm_siren_controller.sv
// Alarm siren controller: exit/entry delays, timed siren,
// alarm-memory latch, all timed by an internal tick prescaler.
module alarm_siren_controller #(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned EXIT_DELAY  = 10,
  parameter int unsigned ENTRY_DELAY = 5,
  parameter int unsigned SIREN_TIME  = 30
) (
  input logic                      clk,
  input logic                      rst_n,
  alarm_siren_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    DISARMED  = 3'd0,
    EXIT_DLY  = 3'd1,
    ARMED     = 3'd2,
    ENTRY_DLY = 3'd3,
    ALARM     = 3'd4,
    SILENCED  = 3'd5
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] EXIT_T  = 8'(EXIT_DELAY);
  localparam logic [7:0] ENTRY_T = 8'(ENTRY_DELAY);
  localparam logic [7:0] SIREN_T = 8'(SIREN_TIME);

  logic          trig_m;
  logic          trig_s;
  logic          m_m;
  logic          m_s;
  state_t        state_q;
  state_t        state_d;
  logic [7:0]    rem_q;
  logic [7:0]    rem_d;
  logic [PW-1:0] presc;
  logic          tick;
  logic          moving;
  logic          beep_q;
  logic          siren_q;
  logic          mem_q;

  // Two-flop synchronisers for the asynchronous level inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      m_m    <= 1'b0;
      m_s    <= 1'b0;
    end else begin
      trig_m <= bus.trig;
      trig_s <= trig_m;
      m_m    <= bus.m;
      m_s    <= m_m;
    end
  end

  assign tick   = (presc == PRE_MAX);
  assign moving = (state_d != state_q);

  // Tick prescaler, restarted on every state change so delays are exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (moving || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Next-state and next-remaining decode; disarm overrides everything.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!m_s) begin
      state_d = DISARMED;
      rem_d   = 8'd0;
    end else begin
      case (state_q)
        DISARMED: begin
          if (EXIT_DELAY == 0) begin
            state_d = ARMED;
            rem_d   = 8'd0;
          end else begin
            state_d = EXIT_DLY;
            rem_d   = EXIT_T;
          end
        end
        EXIT_DLY: begin
          if (tick) begin
            if (rem_q <= 8'd1) begin
              state_d = ARMED;
              rem_d   = 8'd0;
            end else begin
              rem_d = rem_q - 8'd1;
            end
          end
        end
        ARMED: begin
          if (trig_s) begin
            if (ENTRY_DELAY == 0) begin
              state_d = ALARM;
              rem_d   = SIREN_T;
            end else begin
              state_d = ENTRY_DLY;
              rem_d   = ENTRY_T;
            end
          end
        end
        ENTRY_DLY: begin
          if (tick) begin
            if (rem_q <= 8'd1) begin
              state_d = ALARM;
              rem_d   = SIREN_T;
            end else begin
              rem_d = rem_q - 8'd1;
            end
          end
        end
        ALARM: begin
          if (bus.ack) begin
            state_d = SILENCED;
            rem_d   = 8'd0;
          end else if (tick) begin
            if (rem_q <= 8'd1) begin
              state_d = SILENCED;
              rem_d   = 8'd0;
            end else begin
              rem_d = rem_q - 8'd1;
            end
          end
        end
        SILENCED: begin
          if (bus.ack && !trig_s) begin
            state_d = ARMED;
            rem_d   = 8'd0;
          end
        end
        default: begin
          state_d = DISARMED;
          rem_d   = 8'd0;
        end
      endcase
    end
  end

  // State and countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISARMED;
      rem_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Registered siren, chirp and alarm-memory outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      siren_q <= 1'b0;
      beep_q  <= 1'b0;
      mem_q   <= 1'b0;
    end else begin
      siren_q <= (state_d == ALARM);
      if (state_d == DISARMED) begin
        mem_q <= 1'b0;
      end else if (state_d == ALARM) begin
        mem_q <= 1'b1;
      end
      if (moving) begin
        beep_q <= 1'b0;
      end else if (state_q != EXIT_DLY &&
                   state_q != ENTRY_DLY) begin
        beep_q <= 1'b0;
      end else if (tick) begin
        beep_q <= ~beep_q;
      end
    end
  end

  assign bus.siren     = siren_q;
  assign bus.beep      = beep_q;
  assign bus.mem_led   = mem_q;
  assign bus.state     = state_q;
  assign bus.remaining = rem_q;

endmodule
